sl_transmitter: RTL and testbench
=================================

# sl_transmitter

Serial-line (SL) word transmitter: accepts a parallel data word over a valid/ready handshake and serialises it LSB-first onto the two-wire SL bus (zeroes line, ones line), followed by an optional odd-parity bit and a stop bit. It sits directly upstream of the SL receiver and drives its `serial_line_zeroes_a` / `serial_line_ones_a` inputs. It runs on the same 16 MHz system clock.

## Interface
- `BIT_PERIOD`, default 32: clocks per bit slot (500 kbit/s at 16 MHz); legal 2..256.
- `PULSE_LEN`, default 16: clocks the line is driven active within a slot; legal 1..BIT_PERIOD-1.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset (one clock, asynchronous active-low reset; fixed).
- `tx_data`  in  32  word to send, bit 0 sent first.
- `tx_len`  in  6  number of data bits, legal 1..32.
- `tx_pe`  in  1  append parity bit when 1.
- `tx_valid`  in  1  request to send; `tx_data`, `tx_len` and `tx_pe` are sampled on the accepting edge.
- `tx_ready`  out  1  block idle, can accept.
- `sl0`  out  1  zeroes line (idle high).
- `sl1`  out  1  ones line (idle high).
- `tx_done`  out  1  one-cycle pulse, word fully sent.
- `tx_err`  out  1  one-cycle pulse, illegal `tx_len` rejected.

## Operation
- Line symbols:
  - idle/gap: sl0=1, sl1=1.
  - data 1: sl1=0, sl0=1.
  - data 0: sl0=0, sl1=1.
  - stop: sl0=0, sl1=0.
- Each slot: active symbol for PULSE_LEN clocks, then gap for BIT_PERIOD-PULSE_LEN clocks.
- Word frame: `tx_len` data slots (LSB first), then parity slot if `tx_pe`=1, then stop slot. Slot count N = tx_len + tx_pe + 1.
- Parity is odd: parity bit = ~^(tx_data masked to `tx_len` bits), so data+parity carry an odd number of ones.
- Handshake: accept when tx_valid=1 and tx_ready=1 at a rising edge. Inputs are latched into a shift register, length counter and parity flag at that edge; later changes on the inputs are ignored.
- FSM states:
  - IDLE: tx_ready=1. On accept with legal length → DATA. On accept with tx_len=0 or tx_len>32 → IDLE, pulse tx_err, no line activity.
  - DATA: cycle_cnt counts 0..BIT_PERIOD-1. At wrap, shift out the next bit. After the last data bit → PARITY if pe, else STOP.
  - PARITY: one slot → STOP.
  - STOP: one slot → IDLE, pulse tx_done.
- cycle_cnt is 8 bits. bit_cnt is 6 bits and compared against the latched length.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: sl0=1, sl1=1, tx_ready=1, tx_done=0, tx_err=0, FSM in IDLE, counters and shift register cleared.
- Reset asserted mid-word:
  - Lines return to idle immediately (asynchronously).
  - The word is lost; no tx_done.
  - The block is ready on the first edge after release.

## Timing
- Accepting edge E0: tx_ready falls at E0. Slot k (k=0..N-1) symbol is driven from edge E0+k·BIT_PERIOD for PULSE_LEN clocks, then the gap.
- At edge E0+N·BIT_PERIOD: tx_done=1 for one cycle, tx_ready=1, lines idle.
- Earliest next accept is E0+N·BIT_PERIOD+1, so the inter-word idle time is the stop gap plus one clock.
- Illegal-length accept: tx_err=1 during the cycle after the edge; tx_ready stays 1; a new request can be taken on the next edge.
- tx_valid while busy is ignored and not queued; the requester holds tx_valid until tx_ready.
- With default parameters, the receiver's strobe point falls inside the PULSE_LEN window.

## Test plan
- Reset → sl0=sl1=1, tx_ready=1, tx_done=tx_err=0. Assert rst_n=0 at slot 3 of a word → lines are 1 immediately, no tx_done.
- tx_data=0xA5, tx_len=8, tx_pe=1 → slot symbols 1,0,1,0,0,1,0,1, parity 1, stop. Exactly 10·32=320 clocks; tx_done pulses at E0+320.
- tx_data=0x3, tx_len=2, tx_pe=1 → symbols 1,1, parity 1, stop. Same data with tx_pe=0 → 1,1, stop; tx_done at E0+96.
- tx_data=0xFFFFFFFF, tx_len=32, tx_pe=1 → 32 ones, parity 1, stop: 34 slots. Then tx_len=0 → tx_err pulse, lines stay idle, tx_ready stays 1. Then tx_len=33 → tx_err pulse.
- Back-to-back: tx_valid held high with two words → second accept at E0+N·32+1. tx_data changed mid-word does not alter the line.
- Loopback to the SL receiver: 0x5A, 8 bits, pe=1 → receiver reports word received with data 0x5A, no parity/length/level error.

Source files
------------

// File: rtl/sl_transmitter.sv
// sl_transmitter: serialises a parallel word LSB-first onto the two-wire SL bus.
// Each bit slot drives its symbol for PULSE_LEN clocks, then leaves a gap.
// The word is followed by an optional odd-parity slot and a stop slot.
// All outputs come straight from flops, so there is no input-to-output path.
module sl_transmitter #(
  parameter int BIT_PERIOD = 32,
  parameter int PULSE_LEN  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] tx_data,
  input  logic [5:0]  tx_len,
  input  logic        tx_pe,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        sl0,
  output logic        sl1,
  output logic        tx_done,
  output logic        tx_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  // Last counter value of a slot; the comparison width allows PULSE_LEN up to 255.
  localparam logic [7:0] LAST_CNT = 8'(BIT_PERIOD - 1);
  localparam logic [8:0] PULSE_W  = 9'(PULSE_LEN);

  // Odd parity over the low len bits: data plus parity carry an odd number of ones.
  function automatic logic odd_parity(input logic [31:0] data, input logic [5:0] len);
    logic [31:0] mask;
    if (len >= 6'd32) begin
      mask = 32'hFFFF_FFFF;
    end else begin
      mask = (32'd1 << len) - 32'd1;
    end
    return ~^(data & mask);
  endfunction

  // Active line symbol {sl0, sl1} for a slot of the given kind.
  function automatic logic [1:0] line_symbol(input logic [1:0] st, input logic data_bit,
                                             input logic par_bit);
    logic [1:0] sym;
    case (st)
      S_DATA:   sym = data_bit ? 2'b10 : 2'b01;
      S_PARITY: sym = par_bit  ? 2'b10 : 2'b01;
      S_STOP:   sym = 2'b00;
      default:  sym = 2'b11;
    endcase
    return sym;
  endfunction

  logic [1:0]  state_r, state_s;
  logic [7:0]  cycle_cnt_r, cycle_cnt_s;
  logic [5:0]  bit_cnt_r, bit_cnt_s;
  logic [31:0] shift_r, shift_s;
  logic [5:0]  len_r, len_s;
  logic        pe_r, pe_s;
  logic        par_r, par_s;
  logic        done_s, err_s;
  logic        ready_s;
  logic [1:0]  lines_s;
  logic        len_legal_s;
  logic        slot_end_s;

  logic        sl0_r, sl1_r, tx_ready_r, tx_done_r, tx_err_r;

  assign len_legal_s = (tx_len != 6'd0) && (tx_len <= 6'd32);
  assign slot_end_s  = (cycle_cnt_r == LAST_CNT);

  // Next-state logic: handshake, slot counting, bit shifting and frame sequencing.
  always_comb begin
    state_s     = state_r;
    cycle_cnt_s = cycle_cnt_r;
    bit_cnt_s   = bit_cnt_r;
    shift_s     = shift_r;
    len_s       = len_r;
    pe_s        = pe_r;
    par_s       = par_r;
    done_s      = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (tx_valid) begin
          if (len_legal_s) begin
            state_s     = S_DATA;
            cycle_cnt_s = 8'd0;
            bit_cnt_s   = 6'd0;
            shift_s     = tx_data;
            len_s       = tx_len;
            pe_s        = tx_pe;
            par_s       = odd_parity(tx_data, tx_len);
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_DATA: begin
        if (slot_end_s) begin
          cycle_cnt_s = 8'd0;
          if (bit_cnt_r == (len_r - 6'd1)) begin
            state_s = pe_r ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_s = bit_cnt_r + 6'd1;
            shift_s   = {1'b0, shift_r[31:1]};
          end
        end else begin
          cycle_cnt_s = cycle_cnt_r + 8'd1;
        end
      end
      S_PARITY: begin
        if (slot_end_s) begin
          cycle_cnt_s = 8'd0;
          state_s     = S_STOP;
        end else begin
          cycle_cnt_s = cycle_cnt_r + 8'd1;
        end
      end
      S_STOP: begin
        if (slot_end_s) begin
          cycle_cnt_s = 8'd0;
          bit_cnt_s   = 6'd0;
          shift_s     = 32'd0;
          state_s     = S_IDLE;
          done_s      = 1'b1;
        end else begin
          cycle_cnt_s = cycle_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s     = S_IDLE;
        cycle_cnt_s = 8'd0;
        bit_cnt_s   = 6'd0;
      end
    endcase
  end

  // Output decode from the next state so the flops present each symbol on its slot edge.
  always_comb begin
    ready_s = 1'b0;
    lines_s = 2'b11;
    if (state_s == S_IDLE) begin
      ready_s = 1'b1;
      lines_s = 2'b11;
    end else begin
      ready_s = 1'b0;
      if ({1'b0, cycle_cnt_s} < PULSE_W) begin
        lines_s = line_symbol(state_s, shift_s[0], par_s);
      end else begin
        lines_s = 2'b11;
      end
    end
  end

  // State, datapath and output registers; reset idles the lines at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cycle_cnt_r <= 8'd0;
      bit_cnt_r   <= 6'd0;
      shift_r     <= 32'd0;
      len_r       <= 6'd0;
      pe_r        <= 1'b0;
      par_r       <= 1'b0;
      sl0_r       <= 1'b1;
      sl1_r       <= 1'b1;
      tx_ready_r  <= 1'b1;
      tx_done_r   <= 1'b0;
      tx_err_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      cycle_cnt_r <= cycle_cnt_s;
      bit_cnt_r   <= bit_cnt_s;
      shift_r     <= shift_s;
      len_r       <= len_s;
      pe_r        <= pe_s;
      par_r       <= par_s;
      sl0_r       <= lines_s[1];
      sl1_r       <= lines_s[0];
      tx_ready_r  <= ready_s;
      tx_done_r   <= done_s;
      tx_err_r    <= err_s;
    end
  end

  assign sl0      = sl0_r;
  assign sl1      = sl1_r;
  assign tx_ready = tx_ready_r;
  assign tx_done  = tx_done_r;
  assign tx_err   = tx_err_r;

endmodule

// File: tb/tb_sl_transmitter.sv
// Bench for sl_transmitter: directed and random words checked clock by clock
// against a slot-level model of the expected line waveform.
module tb_sl_transmitter;

  localparam int BP = 32;
  localparam int PL = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] tx_data;
  logic [5:0]  tx_len;
  logic        tx_pe;
  logic        tx_valid;
  logic        tx_ready, sl0, sl1, tx_done, tx_err;

  int vectors     = 0;
  int miscompares = 0;

  // Expected slot symbols: 0 = data zero, 1 = data one, 2 = stop.
  int exp_sym [0:33];
  int exp_n;

  sl_transmitter #(.BIT_PERIOD(BP), .PULSE_LEN(PL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_len   (tx_len),
    .tx_pe    (tx_pe),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .sl0      (sl0),
    .sl1      (sl1),
    .tx_done  (tx_done),
    .tx_err   (tx_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  // Build the slot list of a word from the frame rules.
  task automatic build(input logic [31:0] d, input int len, input logic pe);
    int ones;
    ones  = 0;
    exp_n = 0;
    for (int i = 0; i < len; i++) begin
      exp_sym[exp_n] = int'(d[i]);
      ones += int'(d[i]);
      exp_n++;
    end
    if (pe) begin
      exp_sym[exp_n] = (ones % 2 == 0) ? 1 : 0;
      exp_n++;
    end
    exp_sym[exp_n] = 2;
    exp_n++;
  endtask

  // Expected {sl0, sl1, tx_ready, tx_done, tx_err} t clocks after the accepting edge.
  function automatic logic [4:0] model(input int t);
    int slot, off;
    slot = t / BP;
    off  = t % BP;
    if (slot >= exp_n) begin
      return (t == exp_n * BP) ? 5'b11110 : 5'b11100;
    end
    if (off < PL) begin
      case (exp_sym[slot])
        0:       return 5'b01000;
        1:       return 5'b10000;
        default: return 5'b00000;
      endcase
    end
    return 5'b11000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int t, input logic [4:0] expv);
    logic [4:0] obs;
    obs = {sl0, sl1, tx_ready, tx_done, tx_err};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s t=%0d observed {sl0,sl1,rdy,done,err}=%b expected %b", tag, t, obs, expv);
    end
  endtask

  // Called just after the accepting edge: checks the whole frame up to the tx_done
  // cycle, and right after the first check drives the next input values.
  task automatic expect_word(input string tag, input logic [31:0] d, input int len,
                             input logic pe, input logic [31:0] nd, input logic [5:0] nl,
                             input logic np, input logic nv);
    build(d, len, pe);
    for (int t = 0; t <= exp_n * BP; t++) begin
      chk(tag, t, model(t));
      if (t == 0) begin
        tx_data  = nd;
        tx_len   = nl;
        tx_pe    = np;
        tx_valid = nv;
      end
      if (t < exp_n * BP) tick();
    end
  endtask

  // Request a word, let it go through, then check that tx_done dropped.
  task automatic send(input string tag, input logic [31:0] d, input int len, input logic pe);
    tx_data  = d;
    tx_len   = 6'(len);
    tx_pe    = pe;
    tx_valid = 1'b1;
    tick();
    expect_word(tag, d, len, pe, $urandom, 6'(len), ~pe, 1'b0);
    tick();
    chk({tag, "_after"}, exp_n * BP + 1, 5'b11100);
  endtask

  initial begin
    logic [31:0] rd;
    int          rl;
    logic        rp;

    rst_n    = 1'b0;
    tx_data  = 32'd0;
    tx_len   = 6'd0;
    tx_pe    = 1'b0;
    tx_valid = 1'b0;
    #22;
    chk("reset", 0, 5'b11100);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle", 0, 5'b11100);

    // Directed frames from the test plan.
    send("a5_pe", 32'h0000_00A5, 8, 1'b1);
    send("3_pe", 32'h0000_0003, 2, 1'b1);
    send("3_nope", 32'h0000_0003, 2, 1'b0);
    send("ones32", 32'hFFFF_FFFF, 32, 1'b1);

    // Illegal lengths, then a legal word accepted on the very next edge.
    tx_len   = 6'd0;
    tx_valid = 1'b1;
    tick();
    chk("len0_err", 0, 5'b11101);
    tx_len = 6'd33;
    tick();
    chk("len33_err", 0, 5'b11101);
    tx_valid = 1'b0;
    tick();
    chk("err_drop", 0, 5'b11100);
    tx_len   = 6'd33;
    tx_valid = 1'b1;
    tick();
    chk("len33_err2", 0, 5'b11101);
    tx_data = 32'h0000_005A;
    tx_len  = 6'd8;
    tx_pe   = 1'b1;
    tick();
    expect_word("5a_after_err", 32'h0000_005A, 8, 1'b1, 32'hDEAD_BEEF, 6'd8, 1'b0, 1'b0);
    tick();
    chk("5a_after", 0, 5'b11100);

    // Back-to-back with tx_valid held; the second word's data is presented mid-frame.
    tx_data  = 32'h0000_0003;
    tx_len   = 6'd2;
    tx_pe    = 1'b0;
    tx_valid = 1'b1;
    tick();
    expect_word("b2b_first", 32'h0000_0003, 2, 1'b0, 32'h0000_000C, 6'd4, 1'b1, 1'b1);
    tick();
    expect_word("b2b_second", 32'h0000_000C, 4, 1'b1, 32'h0, 6'd4, 1'b0, 1'b0);
    tick();
    chk("b2b_after", 0, 5'b11100);

    // Reset in slot 3 of a word: lines idle immediately, no tx_done afterwards.
    tx_data  = 32'h0000_00A5;
    tx_len   = 6'd8;
    tx_pe    = 1'b1;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    build(32'h0000_00A5, 8, 1'b1);
    for (int t = 0; t < 3 * BP + 3; t++) begin
      chk("pre_rst", t, model(t));
      tick();
    end
    chk("slot3", 3 * BP + 3, model(3 * BP + 3));
    rst_n = 1'b0;
    #1;
    chk("rst_async", 0, 5'b11100);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst", i, 5'b11100);
    end
    send("post_rst_word", 32'h0000_0006, 3, 1'b1);

    // Random frames.
    for (int i = 0; i < 12; i++) begin
      rd = $urandom;
      rl = int'($urandom_range(1, 32));
      rp = 1'($urandom_range(0, 1));
      send("rand", rd, rl, rp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
